// File: rtl/dds_pkg.sv
// Shared DDS definitions: waveform codes, width defaults, midscale code and
// the quarter-wave sine table (Q[i] = round(127*sin(2*pi*(i+0.5)/256))).
package dds_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;
    localparam logic [DW_DEF-1:0] MIDSCALE = 8'd128;

    typedef enum logic [1:0] {
        WAVE_SINE   = 2'd0,
        WAVE_SQUARE = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_SAW    = 2'd3
    } wave_e;

    typedef struct packed {
        wave_e      wave;
        logic [7:0] amp;
    } cfg_t;

    localparam logic [6:0] QSINE [64] = '{
        7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
        7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
        7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
        7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
        7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
        7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
        7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
        7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
    };

endpackage

// File: rtl/dds_quarter_rom.sv
// 64x7 quarter-sine magnitude table with a registered read port.
// Latency 1 cycle, reads every cycle; no flow control.
module dds_quarter_rom
    import dds_pkg::*;
(
    input  logic       clk,
    input  logic [5:0] idx,
    output logic [6:0] mag
);

    always_ff @(posedge clk) begin
        mag <= QSINE[idx];
    end

endmodule

// File: rtl/dds_wave_gen.sv
// DDS phase-to-amplitude stage: sine/square/triangle/saw, scaled by amp/256.
// Latency 3 cycles, one sample per cycle, no backpressure; config swaps only on phase wrap.
module dds_wave_gen
    import dds_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr_in,
    input  logic          addr_vld,
    input  logic [1:0]    wave_sel,
    input  logic [7:0]    amp,
    input  logic          cfg_load,
    output logic          cfg_busy,
    output logic [DW-1:0] dac_out,
    output logic          dac_vld
);

    cfg_t          act_cfg;
    cfg_t          pend_cfg;
    cfg_t          use_cfg;
    logic [AW-1:0] last_addr;
    logic          first_smp;
    logic          wrap;

    logic          s1_vld;
    logic [AW-1:0] s1_addr;
    cfg_t          s1_cfg;
    logic [5:0]    rom_idx;
    logic [6:0]    rom_mag;

    logic          s2_vld;
    logic [AW-1:0] s2_addr;
    cfg_t          s2_cfg;
    logic signed [7:0]  s2_s;
    logic signed [15:0] prod;
    logic signed [7:0]  scaled;

    // The wrapping sample itself already uses the pending config.
    always_comb begin
        wrap    = addr_vld && (first_smp || (addr_in < last_addr));
        use_cfg = (wrap && cfg_busy) ? pend_cfg : act_cfg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_cfg   <= '{wave: WAVE_SINE, amp: 8'd255};
            pend_cfg  <= '{wave: WAVE_SINE, amp: 8'd0};
            cfg_busy  <= 1'b0;
            last_addr <= '0;
            first_smp <= 1'b1;
        end else begin
            if (addr_vld) begin
                last_addr <= addr_in;
                first_smp <= 1'b0;
                act_cfg   <= use_cfg;
            end
            if (cfg_load) begin
                pend_cfg <= '{wave: wave_e'(wave_sel), amp: amp};
                cfg_busy <= 1'b1;
            end else if (wrap) begin
                cfg_busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
        end else begin
            s1_vld <= addr_vld;
            s2_vld <= s1_vld;
        end
    end

    // Data path runs every cycle so fields stay aligned with the ROM output.
    always_ff @(posedge clk) begin
        s1_addr <= addr_in;
        s1_cfg  <= use_cfg;
        s2_addr <= s1_addr;
        s2_cfg  <= s1_cfg;
    end

    assign rom_idx = s1_addr[6] ? ~s1_addr[5:0] : s1_addr[5:0];

    dds_quarter_rom u_rom (
        .clk (clk),
        .idx (rom_idx),
        .mag (rom_mag)
    );

    always_comb begin
        s2_s = '0;
        case (s2_cfg.wave)
            WAVE_SINE:   s2_s = s2_addr[7] ? -$signed({1'b0, rom_mag}) : $signed({1'b0, rom_mag});
            WAVE_SQUARE: s2_s = s2_addr[7] ? -8'sd127 : 8'sd127;
            WAVE_TRI:    s2_s = s2_addr[7] ? $signed(8'd127 - {s2_addr[6:0], 1'b0})
                                           : $signed({s2_addr[6:0], 1'b0} - 8'd128);
            WAVE_SAW:    s2_s = $signed({~s2_addr[7], s2_addr[6:0]});
        endcase
        prod   = $signed({{8{s2_s[7]}}, s2_s}) * $signed({8'd0, s2_cfg.amp});
        scaled = 8'(prod >>> 8);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dac_vld <= 1'b0;
            dac_out <= MIDSCALE;
        end else begin
            dac_vld <= s2_vld;
            if (s2_vld) begin
                dac_out <= MIDSCALE + $unsigned(scaled);
            end
        end
    end

endmodule

// File: tb/tb_dds_wave_gen.sv
// Directed bench for dds_wave_gen: hand-computed DAC codes per waveform,
// config swap on phase wrap, bubbles and mid-stream reset.
module tb_dds_wave_gen;

    localparam logic [1:0] W_SINE = 2'd0;
    localparam logic [1:0] W_SQ   = 2'd1;
    localparam logic [1:0] W_TRI  = 2'd2;
    localparam logic [1:0] W_SAW  = 2'd3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] addr_in = '0;
    logic       addr_vld = 1'b0;
    logic [1:0] wave_sel = '0;
    logic [7:0] amp = '0;
    logic       cfg_load = 1'b0;
    logic       cfg_busy;
    logic [7:0] dac_out;
    logic       dac_vld;

    int total = 0;
    int bad   = 0;
    int seq   = 0;
    logic       obs_vld [2048];
    logic [7:0] obs_dat [2048];

    dds_wave_gen #(.AW(8), .DW(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .addr_in  (addr_in),
        .addr_vld (addr_vld),
        .wave_sel (wave_sel),
        .amp      (amp),
        .cfg_load (cfg_load),
        .cfg_busy (cfg_busy),
        .dac_out  (dac_out),
        .dac_vld  (dac_vld)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One input cycle; output seen now belongs to the drive two calls back.
    task automatic cyc(input logic v, input logic [7:0] a, input logic ld,
                       input logic [1:0] ws, input logic [7:0] am);
        addr_vld = v;
        addr_in  = a;
        cfg_load = ld;
        wave_sel = ws;
        amp      = am;
        step();
        if (seq >= 2 && seq - 2 < 2048) begin
            obs_vld[seq-2] = dac_vld;
            obs_dat[seq-2] = dac_out;
        end
        seq++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'd0, 1'b0, 2'd0, 8'd0);
    endtask

    task automatic apply_cfg(input logic [1:0] ws, input logic [7:0] am);
        cyc(1'b0, 8'd0, 1'b1, ws, am);
        cyc(1'b1, 8'd255, 1'b0, 2'd0, 8'd0);
        cyc(1'b1, 8'd0, 1'b0, 2'd0, 8'd0);
        idle(2);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'(40 + i), 1'b1, W_SAW, 8'd77);
        total++;
        if (dac_out !== 8'd128) begin
            bad++; $display("FAIL reset_dac_out: got %0d want 128", dac_out);
        end
        total++;
        if (dac_vld !== 1'b0) begin
            bad++; $display("FAIL reset_dac_vld: got %0b want 0", dac_vld);
        end
        total++;
        if (cfg_busy !== 1'b0) begin
            bad++; $display("FAIL reset_cfg_busy: got %0b want 0", cfg_busy);
        end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_first_sample();
        int k;
        k = seq;
        cyc(1'b1, 8'd0, 1'b0, 2'd0, 8'd0);
        idle(3);
        total++;
        if (obs_vld[k] !== 1'b1 || obs_dat[k] !== 8'd129) begin
            bad++; $display("FAIL first_sample: got vld=%0b dat=%0d want vld=1 dat=129", obs_vld[k], obs_dat[k]);
        end
        total++;
        if (obs_vld[k+1] !== 1'b0 || obs_dat[k+1] !== 8'd129) begin
            bad++; $display("FAIL first_bubble_hold: got vld=%0b dat=%0d want vld=0 dat=129", obs_vld[k+1], obs_dat[k+1]);
        end
    endtask

    task automatic test_sine_points();
        int a_tab [5] = '{32, 64, 128, 192, 255};
        int e_tab [5] = '{218, 254, 126, 1, 126};
        int k;
        k = seq;
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(a_tab[i]), 1'b0, 2'd0, 8'd0);
        idle(2);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (obs_vld[k+i] !== 1'b1 || obs_dat[k+i] !== 8'(e_tab[i])) begin
                bad++; $display("FAIL sine_addr%0d: got vld=%0b dat=%0d want vld=1 dat=%0d", a_tab[i], obs_vld[k+i], obs_dat[k+i], e_tab[i]);
            end
        end
    endtask

    task automatic test_square();
        int e_tab [4] = '{254, 1, 128, 128};
        int k [4];
        apply_cfg(W_SQ, 8'd255);
        k[0] = seq; cyc(1'b1, 8'd0, 1'b0, 2'd0, 8'd0);
        k[1] = seq; cyc(1'b1, 8'd128, 1'b0, 2'd0, 8'd0);
        idle(2);
        apply_cfg(W_SQ, 8'd0);
        k[2] = seq; cyc(1'b1, 8'd0, 1'b0, 2'd0, 8'd0);
        k[3] = seq; cyc(1'b1, 8'd128, 1'b0, 2'd0, 8'd0);
        idle(2);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (obs_vld[k[i]] !== 1'b1 || obs_dat[k[i]] !== 8'(e_tab[i])) begin
                bad++; $display("FAIL square_%0d: got vld=%0b dat=%0d want vld=1 dat=%0d", i, obs_vld[k[i]], obs_dat[k[i]], e_tab[i]);
            end
        end
    endtask

    task automatic test_saw_tri();
        int a_tab [7] = '{0, 128, 255, 0, 64, 128, 255};
        int e_tab [7] = '{0, 128, 254, 0, 128, 254, 1};
        int k [7];
        apply_cfg(W_SAW, 8'd255);
        for (int i = 0; i < 3; i++) begin
            k[i] = seq; cyc(1'b1, 8'(a_tab[i]), 1'b0, 2'd0, 8'd0);
        end
        idle(2);
        apply_cfg(W_TRI, 8'd255);
        for (int i = 3; i < 7; i++) begin
            k[i] = seq; cyc(1'b1, 8'(a_tab[i]), 1'b0, 2'd0, 8'd0);
        end
        idle(2);
        for (int i = 0; i < 7; i++) begin
            total++;
            if (obs_vld[k[i]] !== 1'b1 || obs_dat[k[i]] !== 8'(e_tab[i])) begin
                bad++; $display("FAIL %s_addr%0d: got vld=%0b dat=%0d want vld=1 dat=%0d", (i < 3) ? "saw" : "tri", a_tab[i], obs_vld[k[i]], obs_dat[k[i]], e_tab[i]);
            end
        end
    endtask

    task automatic test_ramp_switch();
        int off_tab [7] = '{50, 64, 128, 192, 255, 256, 257};
        int e_tab [7]   = '{247, 254, 126, 1, 126, 254, 254};
        int base;
        apply_cfg(W_SINE, 8'd255);
        base = seq;
        for (int a = 0; a < 256; a++) begin
            cyc(1'b1, 8'(a), a == 50, W_SQ, 8'd255);
            if (a == 50) begin
                total++;
                if (cfg_busy !== 1'b1) begin
                    bad++; $display("FAIL ramp_busy_set: got %0b want 1", cfg_busy);
                end
            end
        end
        total++;
        if (cfg_busy !== 1'b1) begin
            bad++; $display("FAIL ramp_busy_before_wrap: got %0b want 1", cfg_busy);
        end
        cyc(1'b1, 8'd0, 1'b0, 2'd0, 8'd0);
        total++;
        if (cfg_busy !== 1'b0) begin
            bad++; $display("FAIL ramp_busy_clear: got %0b want 0", cfg_busy);
        end
        cyc(1'b1, 8'd1, 1'b0, 2'd0, 8'd0);
        idle(2);
        for (int i = 0; i < 7; i++) begin
            total++;
            if (obs_vld[base+off_tab[i]] !== 1'b1 || obs_dat[base+off_tab[i]] !== 8'(e_tab[i])) begin
                bad++; $display("FAIL ramp_sample%0d: got vld=%0b dat=%0d want vld=1 dat=%0d", off_tab[i], obs_vld[base+off_tab[i]], obs_dat[base+off_tab[i]], e_tab[i]);
            end
        end
    endtask

    task automatic test_double_cfg();
        int e_tab [5] = '{254, 50, 20, 40, 254};
        int k [5];
        logic [3:0] busy_obs;
        cyc(1'b0, 8'd0, 1'b1, W_TRI, 8'd255);
        cyc(1'b0, 8'd0, 1'b1, W_SAW, 8'd255);
        k[0] = seq; cyc(1'b1, 8'd100, 1'b0, 2'd0, 8'd0);
        k[1] = seq; cyc(1'b1, 8'd50, 1'b0, 2'd0, 8'd0);
        busy_obs[0] = cfg_busy;
        cyc(1'b0, 8'd0, 1'b1, W_TRI, 8'd255);
        busy_obs[1] = cfg_busy;
        k[2] = seq; cyc(1'b1, 8'd10, 1'b1, W_SQ, 8'd255);
        busy_obs[2] = cfg_busy;
        k[3] = seq; cyc(1'b1, 8'd20, 1'b0, 2'd0, 8'd0);
        k[4] = seq; cyc(1'b1, 8'd5, 1'b0, 2'd0, 8'd0);
        busy_obs[3] = cfg_busy;
        idle(2);
        total++;
        if (busy_obs !== 4'b0110) begin
            bad++; $display("FAIL double_cfg_busy_seq: got %b want 0110", busy_obs);
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (obs_vld[k[i]] !== 1'b1 || obs_dat[k[i]] !== 8'(e_tab[i])) begin
                bad++; $display("FAIL double_cfg_%0d: got vld=%0b dat=%0d want vld=1 dat=%0d", i, obs_vld[k[i]], obs_dat[k[i]], e_tab[i]);
            end
        end
    endtask

    task automatic test_toggle_reset();
        logic v_tab [8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        int   a_tab [8]  = '{16, 144, 144, 16, 16, 144, 0, 0};
        int   e_tab [8]  = '{254, 254, 1, 1, 254, 1, 1, 1};
        int k;
        k = seq;
        for (int i = 0; i < 8; i++) cyc(v_tab[i], 8'(a_tab[i]), 1'b0, 2'd0, 8'd0);
        idle(2);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (obs_vld[k+i] !== v_tab[i] || obs_dat[k+i] !== 8'(e_tab[i])) begin
                bad++; $display("FAIL toggle_%0d: got vld=%0b dat=%0d want vld=%0b dat=%0d", i, obs_vld[k+i], obs_dat[k+i], v_tab[i], e_tab[i]);
            end
        end
        cyc(1'b0, 8'd0, 1'b1, W_SAW, 8'd255);
        cyc(1'b1, 8'd30, 1'b0, 2'd0, 8'd0);
        cyc(1'b1, 8'd31, 1'b0, 2'd0, 8'd0);
        rst = 1'b1;
        cyc(1'b1, 8'd32, 1'b0, 2'd0, 8'd0);
        total++;
        if (dac_vld !== 1'b0 || dac_out !== 8'd128 || cfg_busy !== 1'b0) begin
            bad++; $display("FAIL midreset_state: got vld=%0b dat=%0d busy=%0b want vld=0 dat=128 busy=0", dac_vld, dac_out, cfg_busy);
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 8'd0, 1'b0, 2'd0, 8'd0);
            total++;
            if (dac_vld !== 1'b0) begin
                bad++; $display("FAIL midreset_flush%0d: got vld=%0b want 0", i, dac_vld);
            end
        end
        cyc(1'b1, 8'd64, 1'b0, 2'd0, 8'd0);
        cyc(1'b0, 8'd0, 1'b0, 2'd0, 8'd0);
        total++;
        if (dac_vld !== 1'b0) begin
            bad++; $display("FAIL postreset_early: got vld=%0b want 0", dac_vld);
        end
        cyc(1'b0, 8'd0, 1'b0, 2'd0, 8'd0);
        total++;
        if (dac_vld !== 1'b1 || dac_out !== 8'd254) begin
            bad++; $display("FAIL postreset_first: got vld=%0b dat=%0d want vld=1 dat=254", dac_vld, dac_out);
        end
    endtask

    initial begin
        test_reset();
        test_first_sample();
        test_sine_points();
        test_square();
        test_saw_tri();
        test_ramp_switch();
        test_double_cfg();
        test_toggle_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
